instr_fetch: RTL

//  Instruction fetch stage directly downstream of the program counter register.

---
 rtl/instr_fetch.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage sitting directly after the PC register.
//
// A fetch request latches the current PC into the address register. The stage
// then reads one word over a req/ack memory handshake and keeps the result in
// the instruction register until decode accepts it. A flush discards an
// outstanding or held instruction. A request that gets no ack within TIMEOUT
// cycles is aborted.
//
// Parameters
//   WIDTH    data/address width (PC, memory address, instruction)
//   TIMEOUT  max REQ cycles without mem_ack before abort (>= 1)
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   pc           in   current PC value, latched on an accepted fetch
//   fetch_start  in   fetch request at pc
//   flush        in   discard pending/held instruction
//   mem_req      out  memory read request (registered)
//   mem_addr     out  read address, stable while mem_req=1
//   mem_ack      in   read data valid this cycle
//   mem_rdata    in   read data
//   instr        out  instruction register
//   instr_valid  out  instr holds an unconsumed instruction
//   instr_ready  in   decode accepts instr this cycle
//   pc_plus1     out  mem_addr+1, sequential next-PC candidate
//   busy         out  stage is not idle
//   fetch_err    out  one-cycle pulse on timeout abort
module instr_fetch #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pc,
   input  logic             fetch_start,
   input  logic             flush,
   output logic             mem_req,
   output logic [WIDTH-1:0] mem_addr,
   input  logic             mem_ack,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic [WIDTH-1:0] instr,
   output logic             instr_valid,
   input  logic             instr_ready,
   output logic [WIDTH-1:0] pc_plus1,
   output logic             busy,
   output logic             fetch_err
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   // Counter value seen in the last permitted REQ cycle without an ack.
   localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      HOLD
   } state_t;

   state_t           state;
   state_t           state_n;
   logic             mem_req_n;
   logic [WIDTH-1:0] mem_addr_n;
   logic [WIDTH-1:0] instr_n;
   logic             instr_valid_n;
   logic             fetch_err_n;
   logic             discard;
   logic             discard_n;
   logic [CW-1:0]    tcount;
   logic [CW-1:0]    tcount_n;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_req     <= 1'b0;
         mem_addr    <= '0;
         instr       <= '0;
         instr_valid <= 1'b0;
         fetch_err   <= 1'b0;
         discard     <= 1'b0;
         tcount      <= '0;
      end else begin
         mem_req     <= mem_req_n;
         mem_addr    <= mem_addr_n;
         instr       <= instr_n;
         instr_valid <= instr_valid_n;
         fetch_err   <= fetch_err_n;
         discard     <= discard_n;
         tcount      <= tcount_n;
      end
   end

   always_comb begin
      state_n       = state;
      mem_req_n     = mem_req;
      mem_addr_n    = mem_addr;
      instr_n       = instr;
      instr_valid_n = instr_valid;
      fetch_err_n   = 1'b0;
      discard_n     = discard;
      tcount_n      = tcount;

      case (state)
         IDLE: begin
            // flush wins over a simultaneous fetch request
            if (fetch_start && !flush) begin
               mem_addr_n = pc;
               mem_req_n  = 1'b1;
               tcount_n   = '0;
               discard_n  = 1'b0;
               state_n    = REQ;
            end
         end

         REQ: begin
            if (mem_ack) begin
               mem_req_n = 1'b0;
               discard_n = 1'b0;
               state_n   = IDLE;
               // a flush arriving together with the ack also kills the data
               if (!(discard || flush)) begin
                  instr_n       = mem_rdata;
                  instr_valid_n = 1'b1;
                  state_n       = HOLD;
               end
            end else if (tcount == TLAST) begin
               mem_req_n   = 1'b0;
               fetch_err_n = 1'b1;
               discard_n   = 1'b0;
               state_n     = IDLE;
            end else begin
               tcount_n = tcount + CW'(1);
               // the request is never withdrawn; the data is dropped on ack
               if (flush) begin
                  discard_n = 1'b1;
               end
            end
         end

         HOLD: begin
            if (flush) begin
               instr_valid_n = 1'b0;
               state_n       = IDLE;
            end else if (instr_ready) begin
               instr_valid_n = 1'b0;
               state_n       = IDLE;
               // back-to-back fetch without an idle bubble
               if (fetch_start) begin
                  mem_addr_n = pc;
                  mem_req_n  = 1'b1;
                  tcount_n   = '0;
                  discard_n  = 1'b0;
                  state_n    = REQ;
               end
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign pc_plus1 = mem_addr + WIDTH'(1);
   assign busy     = (state != IDLE);

endmodule
